// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// Holds the ROB tag / ALU op widths, the ALU op level-1 encodings (shared
// with the ALU itself), the per-entry record, and the CDB snoop helper used
// both for dispatch bypass and for wakeup of stored entries.
package alu_rs_pkg;

  localparam int ROB_SIZE_WIDTH       = 4;
  localparam int CALC_OP_L1_NUM_WIDTH = 3;
  localparam int XLEN                 = 32;

  typedef logic [ROB_SIZE_WIDTH-1:0]       rob_tag_t;
  typedef logic [CALC_OP_L1_NUM_WIDTH-1:0] op_l1_t;
  typedef logic [XLEN-1:0]                 word_t;

  // Level-1 op follows RV32 funct3; level-2 selects add/sub and srl/sra.
  localparam op_l1_t OP_ADD  = 3'd0;
  localparam op_l1_t OP_SLL  = 3'd1;
  localparam op_l1_t OP_SLT  = 3'd2;
  localparam op_l1_t OP_SLTU = 3'd3;
  localparam op_l1_t OP_XOR  = 3'd4;
  localparam op_l1_t OP_SR   = 3'd5;
  localparam op_l1_t OP_OR   = 3'd6;
  localparam op_l1_t OP_AND  = 3'd7;

  typedef struct packed {
    logic     ready;
    rob_tag_t rob_id;
    word_t    value;
  } cdb_t;

  typedef struct packed {
    logic  busy;
    word_t val;
  } operand_t;

  typedef struct packed {
    op_l1_t   op_l1;
    logic     op_l2;
    word_t    vj;
    word_t    vk;
    logic     qj_busy;
    logic     qk_busy;
    rob_tag_t qj;
    rob_tag_t qk;
    rob_tag_t rob_id;
  } rs_entry_t;

  // Resolve one operand against both result buses. ALU bus wins if both
  // carry the same tag (cannot happen with unique ROB tags).
  function automatic operand_t snoop(logic busy, rob_tag_t tag, word_t val,
                                     cdb_t a, cdb_t b);
    operand_t r;
    r.busy = busy;
    r.val  = val;
    if (busy && a.ready && a.rob_id == tag) begin
      r.busy = 1'b0;
      r.val  = a.value;
    end else if (busy && b.ready && b.rob_id == tag) begin
      r.busy = 1'b0;
      r.val  = b.value;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Bus bundle between decoder/CDB/ALU and the ALU reservation station.
// master: drives dispatch and CDB broadcasts, receives full and issue.
// slave : the reservation station.
interface alu_rs_if;
  import alu_rs_pkg::*;

  // dispatch
  logic     dispatch_valid;
  op_l1_t   dispatch_op_L1;
  logic     dispatch_op_L2;
  word_t    dispatch_vj, dispatch_vk;
  logic     dispatch_qj_busy, dispatch_qk_busy;
  rob_tag_t dispatch_qj, dispatch_qk;
  rob_tag_t dispatch_rob_id;
  // result broadcasts
  logic     alu_cdb_ready;
  rob_tag_t alu_cdb_rob_id;
  word_t    alu_cdb_value;
  logic     lsb_cdb_ready;
  rob_tag_t lsb_cdb_rob_id;
  word_t    lsb_cdb_value;
  // status / issue
  logic     full;
  logic     alu_valid;
  word_t    alu_opr1, alu_opr2;
  rob_tag_t alu_rob_id;
  op_l1_t   alu_op_L1;
  logic     alu_op_L2;

  modport master (
    output dispatch_valid, dispatch_op_L1, dispatch_op_L2, dispatch_vj, dispatch_vk,
           dispatch_qj_busy, dispatch_qk_busy, dispatch_qj, dispatch_qk, dispatch_rob_id,
           alu_cdb_ready, alu_cdb_rob_id, alu_cdb_value,
           lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_value,
    input  full, alu_valid, alu_opr1, alu_opr2, alu_rob_id, alu_op_L1, alu_op_L2
  );

  modport slave (
    input  dispatch_valid, dispatch_op_L1, dispatch_op_L2, dispatch_vj, dispatch_vk,
           dispatch_qj_busy, dispatch_qk_busy, dispatch_qj, dispatch_qk, dispatch_rob_id,
           alu_cdb_ready, alu_cdb_rob_id, alu_cdb_value,
           lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_value,
    output full, alu_valid, alu_opr1, alu_opr2, alu_rob_id, alu_op_L1, alu_op_L2
  );

endinterface

// File: rtl/alu_rs_prio_enc.sv
// Lowest-index priority encoder.
// vec   : request vector
// found : any bit set
// idx   : index of the lowest set bit (0 when none)
module rs_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = |vec;
    idx   = '0;
    // scan downwards so the lowest set bit is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station.
// Holds up to RS_SIZE dispatched ALU instructions, snoops the ALU and LSB
// result buses for pending operands, and issues the lowest-index ready entry
// to the ALU through registered alu_* outputs (one issue, one dispatch per
// cycle).
// Ports:
//   clk_in        clock
//   rst_in        synchronous active-high reset (beats rdy_in and flush)
//   rdy_in        global enable; low holds all state, alu_valid drops
//   need_flush_in ROB misprediction flush
//   io            alu_rs_if.slave: dispatch, CDBs, full, issue outputs
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE       = 8,
  parameter int RS_SIZE_WIDTH = 3
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    rdy_in,
  input  logic    need_flush_in,
  alu_rs_if.slave io
);

  rs_entry_t                ent   [RS_SIZE];
  rs_entry_t                woken [RS_SIZE];
  rs_entry_t                din;
  logic [RS_SIZE-1:0]       busy, free_vec, elig_vec;
  logic                     free_found, iss_found, accept;
  logic [RS_SIZE_WIDTH-1:0] free_idx, iss_idx;
  cdb_t                     alu_cdb, lsb_cdb;
  operand_t                 dj, dk;

  logic                     alu_valid_q;
  word_t                    opr1_q, opr2_q;
  rob_tag_t                 rob_q;
  op_l1_t                   op_l1_q;
  logic                     op_l2_q;

  assign alu_cdb = '{io.alu_cdb_ready, io.alu_cdb_rob_id, io.alu_cdb_value};
  assign lsb_cdb = '{io.lsb_cdb_ready, io.lsb_cdb_rob_id, io.lsb_cdb_value};

  // Eligibility uses stored state only, so a CDB hit never reaches the
  // issue mux in the same cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i] = ~busy[i];
      elig_vec[i] = busy[i] & ~ent[i].qj_busy & ~ent[i].qk_busy;
      woken[i]    = ent[i];
      {woken[i].qj_busy, woken[i].vj} = snoop(ent[i].qj_busy, ent[i].qj, ent[i].vj, alu_cdb, lsb_cdb);
      {woken[i].qk_busy, woken[i].vk} = snoop(ent[i].qk_busy, ent[i].qk, ent[i].vk, alu_cdb, lsb_cdb);
    end
  end

  rs_prio_enc #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) u_free_sel (
    .vec   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) u_issue_sel (
    .vec   (elig_vec),
    .found (iss_found),
    .idx   (iss_idx)
  );

  // Dispatch with same-cycle bypass from either bus.
  always_comb begin
    dj = snoop(io.dispatch_qj_busy, io.dispatch_qj, io.dispatch_vj, alu_cdb, lsb_cdb);
    dk = snoop(io.dispatch_qk_busy, io.dispatch_qk, io.dispatch_vk, alu_cdb, lsb_cdb);
    din         = '0;
    din.op_l1   = io.dispatch_op_L1;
    din.op_l2   = io.dispatch_op_L2;
    din.vj      = dj.val;
    din.vk      = dk.val;
    din.qj_busy = dj.busy;
    din.qk_busy = dk.busy;
    din.qj      = io.dispatch_qj;
    din.qk      = io.dispatch_qk;
    din.rob_id  = io.dispatch_rob_id;
  end

  // free_idx is a non-busy slot, iss_idx a busy one: they never collide,
  // so a slot freed by issue is only reusable from the next cycle on.
  assign accept = io.dispatch_valid & free_found & ~need_flush_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy        <= '0;
      alu_valid_q <= 1'b0;
      opr1_q      <= '0;
      opr2_q      <= '0;
      rob_q       <= '0;
      op_l1_q     <= '0;
      op_l2_q     <= 1'b0;
    end else if (!rdy_in) begin
      alu_valid_q <= 1'b0;
    end else if (need_flush_in) begin
      busy        <= '0;
      alu_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= woken[i];
      alu_valid_q <= iss_found;
      if (iss_found) begin
        opr1_q         <= ent[iss_idx].vj;
        opr2_q         <= ent[iss_idx].vk;
        rob_q          <= ent[iss_idx].rob_id;
        op_l1_q        <= ent[iss_idx].op_l1;
        op_l2_q        <= ent[iss_idx].op_l2;
        busy[iss_idx]  <= 1'b0;
      end
      if (accept) begin
        ent[free_idx]  <= din;
        busy[free_idx] <= 1'b1;
      end
    end
  end

  assign io.full      = &busy;
  assign io.alu_valid = alu_valid_q;
  assign io.alu_opr1  = opr1_q;
  assign io.alu_opr2  = opr2_q;
  assign io.alu_rob_id = rob_q;
  assign io.alu_op_L1 = op_l1_q;
  assign io.alu_op_L2 = op_l2_q;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int RS    = 8;
  localparam int ISS_W = 1 + 2 * XLEN + ROB_SIZE_WIDTH + CALC_OP_L1_NUM_WIDTH + 1;
  typedef logic [ISS_W-1:0] iss_t;

  logic clk_in        = 1'b0;
  logic rst_in        = 1'b1;
  logic rdy_in        = 1'b1;
  logic need_flush_in = 1'b0;

  alu_rs_if bus();

  alu_rs #(.RS_SIZE(RS), .RS_SIZE_WIDTH(3)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .need_flush_in (need_flush_in),
    .io            (bus)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // reference model state
  typedef struct {
    bit       busy;
    op_l1_t   op1;
    logic     op2;
    word_t    vj, vk;
    logic     jb, kb;
    rob_tag_t qj, qk, rob;
  } m_ent_t;
  m_ent_t m [RS];

  function automatic iss_t obs();
    return {bus.alu_valid, bus.alu_opr1, bus.alu_opr2, bus.alu_rob_id, bus.alu_op_L1, bus.alu_op_L2};
  endfunction

  function automatic iss_t want(word_t a, word_t b, rob_tag_t r, op_l1_t o, logic o2);
    return {1'b1, a, b, r, o, o2};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid = 1'b0;
    bus.alu_cdb_ready  = 1'b0;
    bus.lsb_cdb_ready  = 1'b0;
    need_flush_in      = 1'b0;
    rdy_in             = 1'b1;
  endtask

  task automatic drive_disp(op_l1_t op, logic op2, word_t vj, word_t vk, logic jb, rob_tag_t qj,
                            logic kb, rob_tag_t qk, rob_tag_t rob);
    bus.dispatch_valid   = 1'b1;
    bus.dispatch_op_L1   = op;
    bus.dispatch_op_L2   = op2;
    bus.dispatch_vj      = vj;
    bus.dispatch_vk      = vk;
    bus.dispatch_qj_busy = jb;
    bus.dispatch_qj      = qj;
    bus.dispatch_qk_busy = kb;
    bus.dispatch_qk      = qk;
    bus.dispatch_rob_id  = rob;
  endtask

  task automatic cdb(bit use_alu, rob_tag_t tag, word_t val);
    if (use_alu) begin
      bus.alu_cdb_ready = 1'b1; bus.alu_cdb_rob_id = tag; bus.alu_cdb_value = val;
    end else begin
      bus.lsb_cdb_ready = 1'b1; bus.lsb_cdb_rob_id = tag; bus.lsb_cdb_value = val;
    end
  endtask

  task automatic test_reset();
    idle();
    rst_in = 1'b1;
    drive_disp(OP_ADD, 0, 1, 2, 0, 0, 0, 0, 4'd1);
    tick();
    checks++; if (obs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs()); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    rst_in = 1'b0;
    drive_disp(OP_ADD, 0, 1, 2, 0, 0, 0, 0, 4'd9);
    tick();
    // reset with rdy low must still wipe the entry and issue regs
    idle();
    rst_in = 1'b1; rdy_in = 1'b0; need_flush_in = 1'b1;
    tick();
    idle();
    rst_in = 1'b0;
    checks++; if (obs() !== '0) begin errors++; $display("FAIL reset_prio_outputs: got %h want 0", obs()); end
    tick();
    checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL reset_prio_cleared: got %b want 0", bus.alu_valid); end
  endtask

  task automatic test_ready_issue();
    drive_disp(OP_ADD, 0, 32'd5, 32'd7, 0, 0, 0, 0, 4'd3);
    tick();
    idle();
    checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL ready_early: got %b want 0", bus.alu_valid); end
    tick();
    checks++; if (obs() !== want(5, 7, 3, OP_ADD, 0)) begin errors++; $display("FAIL ready_issue: got %h want %h", obs(), want(5, 7, 3, OP_ADD, 0)); end
    tick();
    checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL ready_freed: got %b want 0", bus.alu_valid); end
  endtask

  task automatic test_wakeup();
    drive_disp(OP_OR, 0, 32'd0, 32'd9, 1, 4'd2, 0, 0, 4'd6);
    tick();
    idle();
    tick();
    checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL wake_pending: got %b want 0", bus.alu_valid); end
    cdb(1, 4'd2, 32'h10);
    tick();
    idle();
    checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL wake_no_bypass_issue: got %b want 0", bus.alu_valid); end
    tick();
    checks++; if (obs() !== want(32'h10, 9, 6, OP_OR, 0)) begin errors++; $display("FAIL wake_issue: got %h want %h", obs(), want(32'h10, 9, 6, OP_OR, 0)); end
  endtask

  task automatic test_bypass();
    drive_disp(OP_ADD, 1, 32'd1, 32'd0, 0, 0, 1, 4'd4, 4'd7);
    cdb(0, 4'd4, 32'hFF);
    tick();
    idle();
    tick();
    checks++; if (obs() !== want(1, 32'hFF, 7, OP_ADD, 1)) begin errors++; $display("FAIL bypass_issue: got %h want %h", obs(), want(1, 32'hFF, 7, OP_ADD, 1)); end
  endtask

  task automatic test_full();
    for (int i = 0; i < RS; i++) begin
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fill_not_full_%0d: got %b want 0", i, bus.full); end
      drive_disp(OP_XOR, 0, 32'd0, word_t'(i), 1, rob_tag_t'(8 + i), 0, 0, rob_tag_t'(i));
      tick();
    end
    idle();
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
    cdb(1, 4'd13, 32'h55);
    tick();
    idle();
    checks++; if (bus.full !== 1'b1 || bus.alu_valid !== 1'b0) begin errors++; $display("FAIL full_wake_edge: got full=%b valid=%b want 1/0", bus.full, bus.alu_valid); end
    tick();
    checks++; if (obs() !== want(32'h55, 5, 5, OP_XOR, 0)) begin errors++; $display("FAIL full_issue5: got %h want %h", obs(), want(32'h55, 5, 5, OP_XOR, 0)); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_drop: got %b want 0", bus.full); end
    need_flush_in = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_flush();
    drive_disp(OP_AND, 0, 0, 32'd1, 1, 4'd1, 0, 0, 4'd1);
    tick();
    drive_disp(OP_AND, 0, 32'd2, 0, 0, 0, 1, 4'd2, 4'd2);
    tick();
    drive_disp(OP_SLT, 0, 32'hA, 32'hB, 0, 0, 0, 0, 4'd3);
    tick();
    // entry rob 3 would issue at this edge; the flush wins
    drive_disp(OP_ADD, 0, 32'd4, 32'd4, 0, 0, 0, 0, 4'd4);
    need_flush_in = 1'b1;
    tick();
    idle();
    checks++; if (bus.alu_valid !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL flush_clear: got valid=%b full=%b want 0/0", bus.alu_valid, bus.full); end
    cdb(1, 4'd1, 32'h1); cdb(0, 4'd2, 32'h2);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet_%0d: got %b want 0", i, bus.alu_valid); end
      tick();
    end
  endtask

  task automatic test_rdy_hold();
    drive_disp(OP_SR, 1, 32'h8000_0000, 32'd4, 0, 0, 0, 0, 4'd10);
    tick();
    idle();
    rdy_in = 1'b0;
    drive_disp(OP_ADD, 0, 1, 1, 0, 0, 0, 0, 4'd11);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.dispatch_valid = 1'b0;
      checks++; if (bus.alu_valid !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL rdy_hold_%0d: got valid=%b full=%b want 0/0", i, bus.alu_valid, bus.full); end
    end
    idle();
    tick();
    checks++; if (obs() !== want(32'h8000_0000, 4, 10, OP_SR, 1)) begin errors++; $display("FAIL rdy_resume: got %h want %h", obs(), want(32'h8000_0000, 4, 10, OP_SR, 1)); end
    tick();
    checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL rdy_low_dispatch_dropped: got %b want 0", bus.alu_valid); end
  endtask

  // operand resolution by the broadcast rule: pending + matching ready bus
  task automatic m_resolve(inout logic b, input rob_tag_t q, inout word_t v);
    if (b && bus.alu_cdb_ready && bus.alu_cdb_rob_id == q) begin b = 0; v = bus.alu_cdb_value; end
    else if (b && bus.lsb_cdb_ready && bus.lsb_cdb_rob_id == q) begin b = 0; v = bus.lsb_cdb_value; end
  endtask

  task automatic test_random();
    bit    ev, ef;
    iss_t  ei;
    int    iss, fr;
    m_ent_t n;
    idle();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    foreach (m[i]) m[i].busy = 0;
    for (int c = 0; c < 600; c++) begin
      idle();
      ef = 1;
      foreach (m[i]) if (!m[i].busy) ef = 0;
      rdy_in        = ($urandom_range(0, 7) != 0);
      need_flush_in = ($urandom_range(0, 49) == 0);
      if (!ef && $urandom_range(0, 2) != 0)
        drive_disp(op_l1_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   1'($urandom_range(0, 1)), rob_tag_t'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), rob_tag_t'($urandom_range(0, 3)),
                   rob_tag_t'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) != 0) cdb(1, rob_tag_t'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 1) != 0) begin
        cdb(0, rob_tag_t'($urandom_range(0, 3)), $urandom);
        if (bus.alu_cdb_ready && bus.lsb_cdb_rob_id == bus.alu_cdb_rob_id) bus.lsb_cdb_ready = 1'b0;
      end
      // predict the edge
      ev = 0; ei = '0;
      if (rdy_in && need_flush_in) begin
        foreach (m[i]) m[i].busy = 0;
      end else if (rdy_in) begin
        iss = -1; fr = -1;
        for (int i = 0; i < RS; i++) begin
          if (iss < 0 && m[i].busy && !m[i].jb && !m[i].kb) iss = i;
          if (fr < 0 && !m[i].busy) fr = i;
        end
        if (iss >= 0) begin
          ev = 1;
          ei = want(m[iss].vj, m[iss].vk, m[iss].rob, m[iss].op1, m[iss].op2);
          m[iss].busy = 0;
        end
        for (int i = 0; i < RS; i++) if (m[i].busy) begin
          m_resolve(m[i].jb, m[i].qj, m[i].vj);
          m_resolve(m[i].kb, m[i].qk, m[i].vk);
        end
        if (bus.dispatch_valid && fr >= 0) begin
          n.busy = 1; n.op1 = bus.dispatch_op_L1; n.op2 = bus.dispatch_op_L2;
          n.vj = bus.dispatch_vj; n.vk = bus.dispatch_vk;
          n.jb = bus.dispatch_qj_busy; n.kb = bus.dispatch_qk_busy;
          n.qj = bus.dispatch_qj; n.qk = bus.dispatch_qk; n.rob = bus.dispatch_rob_id;
          m_resolve(n.jb, n.qj, n.vj);
          m_resolve(n.kb, n.qk, n.vk);
          m[fr] = n;
        end
      end
      ef = 1;
      foreach (m[i]) if (!m[i].busy) ef = 0;
      tick();
      checks++; if (bus.alu_valid !== ev) begin errors++; $display("FAIL rand_valid c=%0d: got %b want %b", c, bus.alu_valid, ev); end
      if (ev) begin
        checks++; if (obs() !== ei) begin errors++; $display("FAIL rand_issue c=%0d: got %h want %h", c, obs(), ei); end
      end
      checks++; if (bus.full !== ef) begin errors++; $display("FAIL rand_full c=%0d: got %b want %b", c, bus.full, ef); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_rdy_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation-station entries (power of two, 2..16).
REQ-002 SHALL have parameter RS_SIZE_WIDTH, default 3, log2(RS_SIZE).
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports listed below, clock and reset first.
REQ-004 clk_in  input  1  clock; all state updates on rising edge.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 rdy_in  input  1  global enable; low = hold all state.
REQ-007 need_flush_in  input  1  misprediction flush from ROB.
REQ-008 dispatch_valid  input  1  decoder presents a new ALU-class instruction.
REQ-009 dispatch_op_L1  input  `CALC_OP_L1_NUM_WIDTH  ALU op level 1.
REQ-010 dispatch_op_L2  input  1  ALU op level 2 (add/sub, srl/sra).
REQ-011 dispatch_vj, dispatch_vk  input  32 each  operand values, meaningful when operand ready.
REQ-012 dispatch_qj_busy, dispatch_qk_busy  input  1 each  operand still pending on a ROB tag.
REQ-013 dispatch_qj, dispatch_qk  input  `ROB_SIZE_WIDTH each  producing ROB tag.
REQ-014 dispatch_rob_id  input  `ROB_SIZE_WIDTH  destination ROB tag.
REQ-015 alu_cdb_ready, alu_cdb_rob_id, alu_cdb_value  input  1/`ROB_SIZE_WIDTH/32  ALU result broadcast.
REQ-016 lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_value  input  1/`ROB_SIZE_WIDTH/32  load result broadcast.
REQ-017 full  output  1  combinational, high when no free entry.
REQ-018 alu_valid, alu_opr1, alu_opr2, alu_rob_id, alu_op_L1, alu_op_L2  output  1/32/32/`ROB_SIZE_WIDTH/`CALC_OP_L1_NUM_WIDTH/1  registered issue to ALU.

Function
REQ-019 Entry state: busy, op_L1, op_L2, vj, vk, qj_busy, qk_busy, qj, qk, rob_id.
REQ-020 Dispatch accepted when dispatch_valid && !full && rdy_in && !need_flush_in; written into lowest-index free entry; dispatch while full SHALL be ignored (upstream contract: never asserted).
REQ-021 Dispatch bypass: pending operand whose tag equals a same-cycle CDB tag (either bus, ready high) SHALL be stored as ready with the CDB value.
REQ-022 Wakeup: each busy entry with qj_busy/qk_busy and tag matching a ready CDB bus SHALL capture value and clear the busy flag at that edge; both buses and both operands updated in parallel.
REQ-023 Entry eligible when busy && !qj_busy && !qk_busy using stored state only (no combinational CDB-to-issue path).
REQ-024 Issue: each enabled cycle, lowest-index eligible entry SHALL be copied to alu_* registers with alu_valid=1 and freed at the same edge; no eligible entry -> alu_valid=0.
REQ-025 Latency: entry dispatched ready at edge N -> alu_valid high after edge N+1; operand woken at edge N -> issued at edge N+1 earliest.
REQ-026 At most one issue and one dispatch per cycle; an entry freed by issue SHALL NOT be reused by dispatch in the same edge (full evaluated pre-edge).
REQ-027 full SHALL equal AND of all busy bits.
REQ-028 need_flush_in high (rdy_in high) SHALL clear all busy bits and alu_valid at that edge, overriding dispatch, wakeup and issue.
REQ-029 rdy_in low SHALL hold all entries and drive alu_valid=0 at that edge.
REQ-030 Tag equality compares full `ROB_SIZE_WIDTH bits; ROB tag wrap-around needs no special handling.

Reset
REQ-031 rst_in SHALL clear all busy bits and alu_valid to 0; alu_opr1/alu_opr2/alu_rob_id/alu_op_* reset to 0; full=0 after reset.
REQ-032 Reset SHALL take priority over rdy_in and need_flush_in.

Structure
REQ-033 `ROB_SIZE_WIDTH, `CALC_OP_L1_NUM_WIDTH and RS size macros SHALL live in src/const_param.v; ALU op encodings shared with the ALU.
REQ-034 One sub-module, rs_prio_enc (RS_SIZE-bit vector -> found flag + lowest index), instantiated twice (free select, issue select).

Verification
REQ-035 Dispatch ADD vj=5 vk=7 both ready, rob 3 -> alu_valid, opr1=5, opr2=7, rob_id=3 one cycle later; entry freed.
REQ-036 Dispatch qj=2 pending; two cycles later alu_cdb rob 2 value 0x10 -> issue next cycle with opr1=0x10.
REQ-037 Dispatch qk=4 pending in same cycle lsb_cdb rob 4 value 0xFF -> captured by bypass, issue next cycle, opr2=0xFF.
REQ-038 Fill 8 entries all pending -> full=1; wake entry 5 -> issues, full drops the cycle after its issue.
REQ-039 3 busy entries, need_flush_in with concurrent dispatch -> all entries empty, alu_valid=0, full=0, nothing later issues.
REQ-040 rdy_in low 3 cycles with ready entry -> alu_valid=0, state held; rdy_in high -> issues next edge.
